lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the word-address width of the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 1 bit, a memory request from the pipeline, sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1 bit, 1 for store and 0 for load.
REQ-006 The block SHALL have port funct3, input, 3 bits, the access size: 0=B, 1=H, 2=W, 4=BU, 5=HU.
REQ-007 The block SHALL have port addr, input, 32 bits, the byte address.
REQ-008 The block SHALL have port wdata, input, 32 bits, the store data, right-aligned.
REQ-009 The block SHALL have port rdata, output, 32 bits, the extended load result, registered.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The block SHALL have port err, output, 1 bit, misaligned or illegal funct3 flag, valid with done.
REQ-012 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-013 The block SHALL have ports mem_read and mem_write, outputs, 1 bit each, strobes to the word memory.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W bits, equal to latched addr[ADDR_W+1:2].
REQ-015 The block SHALL have port mem_wdata, output, 32 bits, the word written.
REQ-016 The block SHALL have port mem_rdata, input, 32 bits, combinational read data, valid in the same cycle as mem_read.

Function
REQ-017 The FSM SHALL have states IDLE, RD, WR, RESP and ERR.
REQ-018 In IDLE with req=1, the block SHALL latch we, funct3, addr and wdata at the clock edge; req while busy SHALL be ignored.
REQ-019 An illegal access (H/HU/SH with addr[0]=1, W with addr[1:0]!=0, load funct3 in {3,6,7}, store funct3>2) SHALL go IDLE->ERR; no memory strobe, rdata unchanged.
REQ-020 Loads and SB/SH SHALL go IDLE->RD; SW SHALL go IDLE->WR.
REQ-021 In RD, mem_read SHALL be 1; at the edge, a load captures the selected byte/half of mem_rdata into rdata and moves to RESP; sign-extension applies for B/H and zero-extension for BU/HU.
REQ-022 In RD for SB/SH, the block SHALL merge wdata[7:0]/[15:0] into mem_rdata at byte lane addr[1:0]/half lane addr[1] into a merge register and move to WR; other lanes are preserved.
REQ-023 In WR, mem_write SHALL be 1 for exactly one cycle, mem_wdata = merge register (SB/SH) or latched wdata (SW), then move to RESP.
REQ-024 RESP SHALL assert done=1, err=0 for one cycle; ERR SHALL assert done=1, err=1 for one cycle; both SHALL return to IDLE.
REQ-025 Latency from accept edge to done SHALL be: LW/LB 2 cycles, SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
REQ-026 mem_read and mem_write SHALL never be high in the same cycle, and SHALL be 0 outside RD/WR.
REQ-027 Address bits above ADDR_W+1 SHALL be ignored (wrap modulo 2^ADDR_W words).
REQ-028 A new req SHALL be accepted in the first IDLE cycle following done.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, rdata=0, done=0, err=0, busy=0, mem_read=0, mem_write=0, and clear the merge register.
REQ-030 Reset asserted in RD or WR SHALL abort the access so that no memory write occurs after reset asserts, and SHALL produce no done pulse.

Verification
REQ-031 The bench SHALL cover: memory word 1 = 0x8000_80F1, LB addr 4 -> done 2 cycles later, rdata 0xFFFF_FFF1; LBU addr 7 -> rdata 0x0000_0080.
REQ-032 The bench SHALL cover: word 2 = 0x1122_3344, SB addr 9 wdata 0xAB -> one mem_write, word 2 = 0x1122_AB44, done at cycle 3.
REQ-033 The bench SHALL cover: SW addr 0 wdata 0xDEAD_BEEF, then LW addr 0 -> rdata 0xDEAD_BEEF, 2 cycles each.
REQ-034 The bench SHALL cover: LW addr 6 -> done and err high 1 cycle after accept, no strobe, rdata unchanged.
REQ-035 The bench SHALL cover: SH addr 2 with rst pulsed during RD -> no mem_write, busy=0 immediately, memory unchanged.
REQ-036 The bench SHALL cover: req held high through an access -> exactly one access per done, next accepted in IDLE.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline-side request/response bus plus the word-memory port of the LSU.
//
// Handshake: the pipeline raises req with we/funct3/addr/wdata stable; the LSU
// accepts it on the first rising edge where it is idle (busy=0) and ignores req
// while busy. Completion is a single-cycle done pulse, with err and rdata valid
// in that same cycle. Memory side: mem_read/mem_write are one-cycle strobes;
// mem_rdata must be valid combinationally while mem_read is high, and the
// write takes effect on the edge that ends the mem_write cycle.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              err;
  logic              busy;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Pipeline plus word memory, seen from outside the LSU
  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  rdata, done, err, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  // The LSU itself
  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output rdata, done, err, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a word-wide memory. Handles byte/half/word
// loads with sign or zero extension, word stores directly, and byte/half
// stores as read-modify-write. Misaligned or undefined accesses are reported
// through err without touching memory.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  lsu_mem_ctrl_if.slave       bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;

  logic              illegal;
  logic              accept;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [31:0]       merge_val;

  assign accept = (state_q == S_IDLE) && bus.req;

  // Classify the incoming request: undefined size codes or misalignment
  always_comb begin
    illegal = 1'b0;
    if (bus.we) begin
      if (bus.funct3 > F3_W) illegal = 1'b1;
    end else begin
      if (bus.funct3 == 3'd3 || bus.funct3 == 3'd6 || bus.funct3 == 3'd7) illegal = 1'b1;
    end
    // H and HU share funct3[1:0]=01; both need an even address
    if (bus.funct3[1:0] == 2'b01 && bus.addr[0]) illegal = 1'b1;
    if (bus.funct3 == F3_W && bus.addr[1:0] != 2'b00) illegal = 1'b1;
  end

  // State register; reset drops any access in flight, so strobes vanish at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (illegal)                           state_d = S_ERR;
          else if (bus.we && bus.funct3 == F3_W) state_d = S_WR;
          else                                   state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, purely from state
  always_comb begin
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.busy      = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state_q)
      S_IDLE: bus.busy      = 1'b0;
      S_RD:   bus.mem_read  = 1'b1;
      S_WR:   bus.mem_write = 1'b1;
      S_RESP: bus.done      = 1'b1;
      S_ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: bus.busy = 1'b0;
    endcase
  end

  // Select the addressed byte and half of the fetched word
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  // Extend the selected field into the 32-bit load result
  always_comb begin
    case (funct3_q)
      F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_val = {24'd0, ld_byte};
      F3_HU:   ld_val = {16'd0, ld_half};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  // Splice store data into the fetched word, keeping the other lanes
  always_comb begin
    merge_val = bus.mem_rdata;
    if (funct3_q == F3_B) begin
      case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merge_val[31:16] = wdata_q[15:0];
      else           merge_val[15:0]  = wdata_q[15:0];
    end
  end

  // Request latch, load result and merge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      if (accept) begin
        we_q     <= bus.we;
        funct3_q <= bus.funct3;
        addr_q   <= bus.addr[ADDR_W+1:0];
        wdata_q  <= bus.wdata;
      end
      if (state_q == S_RD) begin
        if (we_q) merge_q <= merge_val;
        else      rdata_q <= ld_val;
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q[ADDR_W+1:2];
  assign bus.mem_wdata = (funct3_q == F3_W) ? wdata_q : merge_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 6;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- word memory model ----------------
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          wr_cnt;
  int          rd_cnt;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_read) rd_cnt <= rd_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_errors;
  logic [32:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      n_checks = n_checks + 1;
      if (bus.mem_read && bus.mem_write) begin
        n_errors = n_errors + 1;
        $display("FAIL strobe_overlap: got read=1 write=1 expected never both");
      end
      if (bus.done) begin
        logic [32:0] e;
        string       nm;
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
          n_errors = n_errors + 1;
          $display("FAIL unexpected_done: got done=1 err=%b expected no response", bus.err);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ({bus.err, bus.rdata} !== e) begin
            n_errors = n_errors + 1;
            $display("FAIL %s resp: got err=%b rdata=%h expected err=%b rdata=%h",
                     nm, bus.err, bus.rdata, e[32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input string nm, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rdata,
                        input int e_lat, input int e_wr, input int e_rd);
    int lat;
    int wr0;
    int rd0;
    bit got;
    @(negedge clk);
    bus.req    = 1'b1;
    bus.we     = w;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = wd;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    exp_q.push_back({e_err, e_rdata});
    name_q.push_back(nm);
    @(posedge clk);
    #1 bus.req = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL %s timeout: got no done expected done within 10 cycles", nm);
    end else begin
      check({nm, " latency"}, lat, e_lat);
      check({nm, " writes"}, wr_cnt - wr0, e_wr);
      check({nm, " reads"}, rd_cnt - rd0, e_rd);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int rd0;
    int wr0;
    bit got;

    n_checks = 0;
    n_errors = 0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
    mem[1] = 32'h8000_80F1;
    mem[2] = 32'h1122_3344;

    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rdata", bus.rdata, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset err", {31'd0, bus.err}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loads with extension
    access("LB a4",  1'b0, 3'd0, 32'd4, 32'd0, 1'b0, 32'hFFFF_FFF1, 2, 0, 1);
    access("LBU a7", 1'b0, 3'd4, 32'd7, 32'd0, 1'b0, 32'h0000_0080, 2, 0, 1);
    access("LH a6",  1'b0, 3'd1, 32'd6, 32'd0, 1'b0, 32'hFFFF_8000, 2, 0, 1);
    access("LHU a4", 1'b0, 3'd5, 32'd4, 32'd0, 1'b0, 32'h0000_80F1, 2, 0, 1);

    // Byte store: read-modify-write, rdata untouched
    access("SB a9", 1'b1, 3'd0, 32'd9, 32'h0000_00AB, 1'b0, 32'h0000_80F1, 3, 1, 1);
    check("SB a9 mem", mem[2], 32'h1122_AB44);

    // Word store then load back
    access("SW a0", 1'b1, 3'd2, 32'd0, 32'hDEAD_BEEF, 1'b0, 32'h0000_80F1, 2, 1, 0);
    check("SW a0 mem", mem[0], 32'hDEAD_BEEF);
    access("LW a0", 1'b0, 3'd2, 32'd0, 32'd0, 1'b0, 32'hDEAD_BEEF, 2, 0, 1);

    // Error cases: no strobes, rdata held
    access("LW a6 misalign",  1'b0, 3'd2, 32'd6, 32'd0, 1'b1, 32'hDEAD_BEEF, 1, 0, 0);
    access("SH a3 misalign",  1'b1, 3'd1, 32'd3, 32'd0, 1'b1, 32'hDEAD_BEEF, 1, 0, 0);
    access("load f3=3",       1'b0, 3'd3, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1, 0, 0);
    access("store f3=4",      1'b1, 3'd4, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1, 0, 0);
    access("LHU a1 misalign", 1'b0, 3'd5, 32'd1, 32'd0, 1'b1, 32'hDEAD_BEEF, 1, 0, 0);

    // Reset during RD of a half store aborts it silently
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'd1;
    bus.addr = 32'd2; bus.wdata = 32'h0000_5566;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 bus.req = 1'b0;
    check("abort in RD busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort writes", wr_cnt - wr0, 32'd0);
    check("abort mem", mem[0], 32'hDEAD_BEEF);
    check("abort rdata", bus.rdata, 32'd0);

    // Half store completes normally, upper half of word 0
    access("SH a2", 1'b1, 3'd1, 32'd2, 32'h1234_5566, 1'b0, 32'd0, 3, 1, 1);
    check("SH a2 mem", mem[0], 32'h5566_BEEF);

    // Upper address bits wrap: 0x104 is word 1
    access("LW wrap", 1'b0, 3'd2, 32'h0000_0104, 32'd0, 1'b0, 32'h8000_80F1, 2, 0, 1);

    // req held high: back-to-back accesses, one per done
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'd2;
    bus.addr = 32'd8; bus.wdata = 32'd0;
    rd0 = rd_cnt;
    exp_q.push_back({1'b0, 32'h1122_AB44}); name_q.push_back("hold #1");
    exp_q.push_back({1'b0, 32'h1122_AB44}); name_q.push_back("hold #2");
    for (int k = 0; k < 2; k++) begin
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        lat++;
        if (bus.done) got = 1'b1;
      end
      if (k == 1) bus.req = 1'b0;
      if (!got) begin
        n_checks = n_checks + 1;
        n_errors = n_errors + 1;
        $display("FAIL hold timeout: got no done expected done within 10 cycles");
      end else begin
        check("hold spacing", lat, (k == 0) ? 32'd2 : 32'd3);
      end
    end
    repeat (3) @(negedge clk);
    check("hold reads", rd_cnt - rd0, 32'd2);
    check("hold idle busy", {31'd0, bus.busy}, 32'd0);

    check("pending responses", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog in case something stalls outside the bounded waits
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
